// File: rtl/alu_ctrl_sequencer_if.sv
// rtl/alu_ctrl_sequencer_if.sv - handshake/control bundle between the sequencer and its environment
//
// Groups the instruction-memory handshake, data-memory handshake, ALU flag and
// the datapath control outputs of alu_ctrl_sequencer.
//   master : the sequencer (consumes instr/instr_valid/zero/mem_ready, drives controls)
//   slave  : the surrounding memories and datapath
interface alu_ctrl_sequencer_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        zero;
  logic        mem_ready;
  logic        instr_req;
  logic [2:0]  ALUctrl;
  logic        alu_src;
  logic [1:0]  imm_sel;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        result_src;
  logic        pc_write;
  logic        pc_src;
  logic        illegal;

  modport master (
    input  instr, instr_valid, zero, mem_ready,
    output instr_req, ALUctrl, alu_src, imm_sel, reg_write, mem_read,
           mem_write, result_src, pc_write, pc_src, illegal
  );

  modport slave (
    output instr, instr_valid, zero, mem_ready,
    input  instr_req, ALUctrl, alu_src, imm_sel, reg_write, mem_read,
           mem_write, result_src, pc_write, pc_src, illegal
  );
endinterface

// File: rtl/alu_ctrl_sequencer.sv
// rtl/alu_ctrl_sequencer.sv - multi-cycle RV32I control FSM for the ALU datapath
//
// Fetches one instruction, decodes it and sequences EXEC/MEM/WB, driving ALU
// op/operand selects, register-file/memory strobes and PC update.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_ctrl_sequencer_if.master: instr/instr_valid/zero/mem_ready in;
//          instr_req, ALUctrl, alu_src, imm_sel, reg_write, mem_read, mem_write,
//          result_src, pc_write, pc_src, illegal out
// Parameters:
//   MEM_TIMEOUT   cycles allowed in MEM without mem_ready (0 = wait forever)
//   ILLEGAL_HALT  1: unsupported instruction halts; 0: skipped as a NOP
module alu_ctrl_sequencer #(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_ctrl_sequencer_if.master  bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CW-1:0] TLAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {K_R, K_I, K_LW, K_SW, K_BR, K_ILL} kind_t;

  state_t state, state_nx;

  // Only the control-relevant instruction fields are kept; register indices
  // and immediates are captured by the datapath's own instruction register.
  logic [6:0]    ir_op;
  logic [2:0]    ir_f3;
  logic          ir_f7b5;
  logic          illegal_q, illegal_set;
  logic [CW-1:0] tcnt;
  logic          timeout_hit;

  kind_t      kind;
  logic [2:0] alu_op;

  logic       req_c, alu_src_c, reg_write_c, mem_read_c, mem_write_c;
  logic       result_src_c, pc_write_c, pc_src_c;
  logic [2:0] alu_ctrl_c;
  logic [1:0] imm_sel_c;

  always_comb begin
    kind   = K_ILL;
    alu_op = 3'b000;
    case (ir_op)
      7'b0110011: begin
        kind = K_R;
        case (ir_f3)
          3'b000:  alu_op = ir_f7b5 ? 3'b001 : 3'b000;
          3'b111:  alu_op = 3'b010;
          3'b110:  alu_op = 3'b011;
          default: kind = K_ILL;
        endcase
      end
      7'b0010011: begin
        kind = K_I;
        case (ir_f3)
          3'b000:  alu_op = 3'b000;
          3'b111:  alu_op = 3'b010;
          3'b110:  alu_op = 3'b011;
          default: kind = K_ILL;
        endcase
      end
      7'b0000011: if (ir_f3 == 3'b010) kind = K_LW;
      7'b0100011: if (ir_f3 == 3'b010) kind = K_SW;
      7'b1100011: begin
        if (ir_f3 == 3'b000 || ir_f3 == 3'b001) begin
          kind   = K_BR;
          alu_op = 3'b001;
        end
      end
      default: kind = K_ILL;
    endcase
  end

  assign timeout_hit = (MEM_TIMEOUT != 0) && (tcnt == TLAST);

  always_comb begin
    state_nx     = state;
    illegal_set  = 1'b0;
    req_c        = 1'b0;
    alu_ctrl_c   = 3'b000;
    alu_src_c    = 1'b0;
    imm_sel_c    = 2'b00;
    reg_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    result_src_c = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 1'b0;
    case (state)
      S_FETCH: begin
        req_c = 1'b1;
        if (bus.instr_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (kind == K_ILL) begin
          illegal_set = 1'b1;
          if (ILLEGAL_HALT) begin
            state_nx = S_HALT;
          end else begin
            pc_write_c = 1'b1;
            state_nx   = S_FETCH;
          end
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC, S_WB: begin
        alu_ctrl_c = alu_op;
        alu_src_c  = (kind != K_R) && (kind != K_BR);
        imm_sel_c  = (kind == K_SW) ? 2'b01 : (kind == K_BR) ? 2'b10 : 2'b00;
        if (state == S_EXEC) begin
          case (kind)
            K_BR: begin
              pc_write_c = 1'b1;
              pc_src_c   = bus.zero ^ ir_f3[0];  // f3[0] set = bne
              state_nx   = S_FETCH;
            end
            K_LW, K_SW: state_nx = S_MEM;
            default:    state_nx = S_WB;
          endcase
        end else begin
          // ALU selects stay applied in WB so the written result is stable.
          reg_write_c  = 1'b1;
          result_src_c = (kind == K_LW);
          pc_write_c   = 1'b1;
          state_nx     = S_FETCH;
        end
      end
      S_MEM: begin
        alu_src_c   = 1'b1;
        imm_sel_c   = (kind == K_SW) ? 2'b01 : 2'b00;
        mem_read_c  = (kind == K_LW);
        mem_write_c = (kind == K_SW);
        if (bus.mem_ready) begin
          if (kind == K_LW) begin
            state_nx = S_WB;
          end else begin
            pc_write_c = 1'b1;
            state_nx   = S_FETCH;
          end
        end else if (timeout_hit) begin
          illegal_set = 1'b1;
          state_nx    = S_HALT;
        end
      end
      default: state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      ir_op     <= 7'd0;
      ir_f3     <= 3'd0;
      ir_f7b5   <= 1'b0;
      illegal_q <= 1'b0;
      tcnt      <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && bus.instr_valid) begin
        ir_op   <= bus.instr[6:0];
        ir_f3   <= bus.instr[14:12];
        ir_f7b5 <= bus.instr[30];
      end
      if (illegal_set) illegal_q <= 1'b1;
      // Held at zero outside MEM, so every MEM entry starts from a clean count.
      if (state != S_MEM) tcnt <= '0;
      else if (!timeout_hit) tcnt <= tcnt + 1'b1;
    end
  end

  // The async reset forces FETCH; gating keeps instr_req low while rst_n is held.
  assign bus.instr_req  = req_c & rst_n;
  assign bus.ALUctrl    = alu_ctrl_c;
  assign bus.alu_src    = alu_src_c;
  assign bus.imm_sel    = imm_sel_c;
  assign bus.reg_write  = reg_write_c;
  assign bus.mem_read   = mem_read_c;
  assign bus.mem_write  = mem_write_c;
  assign bus.result_src = result_src_c;
  assign bus.pc_write   = pc_write_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// tb/tb_alu_ctrl_sequencer.sv - scoreboard bench for alu_ctrl_sequencer
module tb_alu_ctrl_sequencer;

  typedef struct packed {
    logic [7:0] lat;
    logic [2:0] alu;
    logic       src;
    logic [1:0] imm;
    logic [1:0] regw;
    logic       res;
    logic       pcs;
    logic [7:0] rd;
    logic [7:0] wr;
    logic       ill;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mem_delay = 0;
  int   mcnt = 0;

  ev_t   q_exp[$];
  string q_nm[$];

  alu_ctrl_sequencer_if bus();

  alu_ctrl_sequencer #(.MEM_TIMEOUT(16), .ILLEGAL_HALT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic ev_t mk(int lat, int alu, int src, int imm, int regw,
                             int res, int pcs, int rd, int wr, int ill);
    ev_t e;
    e.lat = 8'(lat); e.alu = 3'(alu); e.src = 1'(src); e.imm = 2'(imm);
    e.regw = 2'(regw); e.res = 1'(res); e.pcs = 1'(pcs);
    e.rd = 8'(rd); e.wr = 8'(wr); e.ill = 1'(ill);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {bus.instr_req, bus.ALUctrl, bus.alu_src, bus.imm_sel, bus.reg_write,
            bus.mem_read, bus.mem_write, bus.result_src, bus.pc_write, bus.pc_src,
            bus.illegal};
  endfunction

  // Data memory model: raise mem_ready in the mem_delay-th MEM cycle (0 = never).
  always @(posedge clk) begin
    #1;
    if (bus.mem_read || bus.mem_write) begin
      mcnt++;
      bus.mem_ready = (mem_delay != 0) && (mcnt == mem_delay);
    end else begin
      mcnt = 0;
      bus.mem_ready = 1'b0;
    end
  end

  // Monitor: reconstructs one event per instruction, closed by pc_write or a
  // rising illegal flag, and compares it against the scoreboard head.
  ev_t  cur;
  int   cyc = 0;
  bit   active = 0;
  logic ill_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      active   = 0;
      ill_prev = 1'b0;
    end else begin
      if (bus.instr_req && bus.instr_valid) begin
        active = 1;
        cyc    = 1;
        cur    = '0;
      end else if (active) begin
        cyc++;
      end
      if (active) begin
        if (cyc == 3) begin
          cur.alu = bus.ALUctrl;
          cur.src = bus.alu_src;
          cur.imm = bus.imm_sel;
        end
        if (bus.mem_read)  cur.rd   = cur.rd + 8'd1;
        if (bus.mem_write) cur.wr   = cur.wr + 8'd1;
        if (bus.reg_write) cur.regw = cur.regw + 2'd1;
        if (bus.pc_write || (bus.illegal && !ill_prev)) begin
          cur.lat = 8'(cyc);
          cur.res = bus.result_src;
          cur.pcs = bus.pc_src;
          cur.ill = bus.illegal;
          if (q_exp.size() == 0) begin
            chk("unexpected_event", 64'(cur), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            chk(q_nm.pop_front(), 64'(cur), 64'(q_exp.pop_front()));
          end
          active = 0;
        end
      end
      ill_prev = bus.illegal;
    end
  end

  task automatic fetch(input logic [31:0] w, input logic z, input int md,
                       input bit push, input string nm, input ev_t e);
    int n;
    if (push) begin
      q_exp.push_back(e);
      q_nm.push_back(nm);
    end
    @(posedge clk); #1;
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.instr_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({nm, "_fetch_timeout"}, 64'(0), 64'(1));
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.zero        = z;
    mem_delay       = md;
  endtask

  task automatic wait_illegal(input string nm);
    int n;
    n = 0;
    while (!bus.illegal && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk({nm, "_wait_timeout"}, 64'(0), 64'(1));
    repeat (2) @(negedge clk);
    chk({nm, "_halt_instr_req"}, 64'(bus.instr_req), 64'(0));
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk({nm, "_outs_in_reset"}, 64'(outs()), 64'(0));
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk({nm, "_instr_req_after"}, 64'(bus.instr_req), 64'(1));
    chk({nm, "_illegal_after"}, 64'(bus.illegal), 64'(0));
  endtask

  initial begin
    int n;
    bus.instr       = 32'd0;
    bus.instr_valid = 1'b0;
    bus.zero        = 1'b0;
    bus.mem_ready   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", 64'(outs()), 64'(0));
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release_instr_req", 64'(bus.instr_req), 64'(1));
    chk("reset_release_illegal", 64'(bus.illegal), 64'(0));

    fetch(32'h002081B3, 1'b0, 0, 1, "add",     mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    fetch(32'h402081B3, 1'b0, 0, 1, "sub",     mk(4, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    fetch(32'h0020E1B3, 1'b0, 0, 1, "or",      mk(4, 3, 0, 0, 1, 0, 0, 0, 0, 0));
    fetch(32'h00500093, 1'b0, 0, 1, "addi",    mk(4, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    fetch(32'h0070F093, 1'b0, 0, 1, "andi",    mk(4, 2, 1, 0, 1, 0, 0, 0, 0, 0));
    fetch(32'h00208463, 1'b1, 0, 1, "beq_z1",  mk(3, 1, 0, 2, 0, 0, 1, 0, 0, 0));
    fetch(32'h00209463, 1'b1, 0, 1, "bne_z1",  mk(3, 1, 0, 2, 0, 0, 0, 0, 0, 0));
    fetch(32'h00209463, 1'b0, 0, 1, "bne_z0",  mk(3, 1, 0, 2, 0, 0, 1, 0, 0, 0));
    fetch(32'h0000A183, 1'b0, 3, 1, "lw_d3",   mk(7, 0, 1, 0, 1, 1, 0, 3, 0, 0));
    fetch(32'h0020A023, 1'b0, 1, 1, "sw_d1",   mk(4, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    fetch(32'h0020A023, 1'b0, 0, 1, "sw_tout", mk(20, 0, 1, 1, 0, 0, 0, 0, 16, 1));
    wait_illegal("sw_tout");
    do_reset("rst1");

    fetch(32'h0000007F, 1'b0, 0, 1, "opc_7f",  mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    wait_illegal("opc_7f");
    do_reset("rst2");

    fetch(32'h0000A183, 1'b0, 0, 0, "lw_abort", '0);
    n = 0;
    while (!bus.mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_mem", 64'(bus.mem_read), 64'(1));
    repeat (2) @(negedge clk);
    do_reset("mem_abort");
    fetch(32'h002081B3, 1'b0, 0, 1, "add_restart", mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    n = 0;
    while (q_exp.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 64'(q_exp.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
